// File: rtl/shift_left_iterative.sv
// Multi-cycle left shifter/rotator: one logarithmic stage per clock (by 8, 4, 2, 1),
// each stage applied only when the matching bit of the latched count is set.
// A start/busy/done handshake lets the execute stage stall while the shift runs.
module shift_left_iterative #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic             Rot,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);

  localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           nextState;
  logic             accept;
  logic [WIDTH-1:0] dataQ;
  logic [WIDTH-1:0] outQ;
  logic [CNT_W-1:0] cntQ;
  logic             rotQ;
  logic [STG_W-1:0] stageQ;
  logic [CNT_W:0]   stepAmt;
  logic [CNT_W:0]   backAmt;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] stepped;
  logic             lastStage;

  // One stage of the shifter: move by 2**stage, wrapping the lost MSBs back in for rotate
  always_comb begin
    stepAmt = (CNT_W + 1)'(1) << stageQ;
    backAmt = (CNT_W + 1)'(WIDTH) - stepAmt;
    shl     = dataQ << stepAmt;
    shr     = dataQ >> backAmt;
    stepped = dataQ;
    if (cntQ[stageQ]) begin
      stepped = rotQ ? (shl | shr) : shl;
    end
  end

  assign lastStage = (stageQ == '0);

  // Next-state logic; a new request is taken in IDLE and also in DONE for back-to-back ops
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (lastStage) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = SHIFT;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State and datapath registers; the visible result only moves when the last stage completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      dataQ  <= '0;
      outQ   <= '0;
      cntQ   <= '0;
      rotQ   <= 1'b0;
      stageQ <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        dataQ  <= In;
        cntQ   <= Cnt;
        rotQ   <= Rot;
        stageQ <= STG_W'(CNT_W - 1);
      end else if (state == SHIFT) begin
        dataQ <= stepped;
        if (lastStage) begin
          outQ <= stepped;
        end else begin
          stageQ <= stageQ - 1'b1;
        end
      end
    end
  end

  assign Out  = outQ;
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_left_iterative.sv
// Bench for shift_left_iterative: table of directed vectors, hand-written handshake
// corner cases (reset, ignored starts, back-to-back, abort) and random operations,
// with expected results queued at request time and compared when done pulses.
module tb_shift_left_iterative;

  localparam int WIDTH   = 16;
  localparam int CNT_W   = 4;
  localparam int LATENCY = 5;
  localparam int TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
  logic             Rot;
  logic [WIDTH-1:0] Out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] scoreboard[$];

  typedef struct {
    logic [WIDTH-1:0] inVal;
    logic [CNT_W-1:0] cntVal;
    logic             rotVal;
    logic [WIDTH-1:0] expVal;
    string            name;
  } vec_t;

  vec_t vectors[10];

  shift_left_iterative #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .In   (In),
    .Cnt  (Cnt),
    .Rot  (Rot),
    .Out  (Out),
    .busy (busy),
    .done (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model: rotate via a doubled word, logical via a plain shift
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] inVal,
                                             input logic [CNT_W-1:0] cntVal,
                                             input logic rotVal);
    logic [2*WIDTH-1:0] both;
    both = {inVal, inVal} << cntVal;
    return rotVal ? both[2*WIDTH-1:WIDTH] : (inVal << cntVal);
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issue one request and leave the bench on the negedge after the accepting edge
  task automatic applyStimulus(input logic [WIDTH-1:0] inVal, input logic [CNT_W-1:0] cntVal,
                               input logic rotVal);
    @(negedge clk);
    In    = inVal;
    Cnt   = cntVal;
    Rot   = rotVal;
    start = 1'b1;
    scoreboard.push_back(model(inVal, cntVal, rotVal));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, checking latency, busy during the run and that Out holds still
  task automatic waitDone(input string name);
    int               cycles;
    bit               busyOk;
    bit               stableOk;
    logic [WIDTH-1:0] heldOut;
    cycles   = 1;
    busyOk   = 1'b1;
    stableOk = 1'b1;
    heldOut  = Out;
    while (!done && cycles < TIMEOUT) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (Out !== heldOut) stableOk = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check({name, " latency"}, 32'(cycles), 32'(LATENCY));
    check({name, " busy while shifting"}, 32'(busyOk), 32'd1);
    check({name, " Out stable while shifting"}, 32'(stableOk), 32'd1);
  endtask

  // Pop the oldest expected result and compare against the DUT output in the done cycle
  task automatic checkOutput(input string name);
    logic [WIDTH-1:0] expVal;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got result %0h, expected nothing queued", name, Out);
    end else begin
      expVal = scoreboard.pop_front();
      check({name, " Out"}, 32'(Out), 32'(expVal));
      check({name, " done/busy"}, 32'({done, busy}), 32'b10);
    end
  endtask

  initial begin
    int  cycles;
    bit  sawDone;
    logic [WIDTH-1:0] rIn;
    logic [CNT_W-1:0] rCnt;
    logic             rRot;

    vectors[0] = '{16'h8001, 4'd8,  1'b1, 16'h0180, "T2 rol 8001 by 8"};
    vectors[1] = '{16'h00FF, 4'd4,  1'b0, 16'h0FF0, "T3 shl 00FF by 4"};
    vectors[2] = '{16'hFFFF, 4'd15, 1'b0, 16'h8000, "T3 shl FFFF by 15"};
    vectors[3] = '{16'hF00F, 4'd15, 1'b1, 16'hF807, "T4 rol F00F by 15"};
    vectors[4] = '{16'h1234, 4'd0,  1'b1, 16'h1234, "T4 rol 1234 by 0"};
    vectors[5] = '{16'hBEEF, 4'd0,  1'b0, 16'hBEEF, "shl by 0"};
    vectors[6] = '{16'h8000, 4'd1,  1'b1, 16'h0001, "rol MSB wraps"};
    vectors[7] = '{16'h0001, 4'd15, 1'b0, 16'h8000, "shl keeps In[0]"};
    vectors[8] = '{16'hFFFE, 4'd15, 1'b0, 16'h0000, "shl drops all but In[0]"};
    vectors[9] = '{16'h1234, 4'd5,  1'b0, 16'h4680, "shl 1234 by 5"};

    // T1: reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    In    = 16'hFFFF;
    Cnt   = 4'd3;
    Rot   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset Out", 32'(Out), 32'h0);
      check("reset busy/done", 32'({busy, done}), 32'b00);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'({busy, done}), 32'b00);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i].inVal, vectors[i].cntVal, vectors[i].rotVal);
      waitDone(vectors[i].name);
      checkOutput(vectors[i].name);
      check({vectors[i].name, " table"}, 32'(Out), 32'(vectors[i].expVal));
    end

    // T5: starts during SHIFT are ignored, start in DONE begins the next op immediately
    applyStimulus(16'h00F0, 4'd3, 1'b0);
    cycles = 1;
    while (!done && cycles < TIMEOUT) begin
      In    = 16'hAAAA;
      Cnt   = 4'hF;
      Rot   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      cycles++;
    end
    check("T5 latency with starts while busy", 32'(cycles), 32'(LATENCY));
    checkOutput("T5 ignored starts");
    In    = 16'h1234;
    Cnt   = 4'd4;
    Rot   = 1'b1;
    start = 1'b1;
    scoreboard.push_back(model(16'h1234, 4'd4, 1'b1));
    @(negedge clk);
    start = 1'b0;
    In    = 16'h0000;
    check("T5 back-to-back no bubble", 32'({busy, done}), 32'b10);
    waitDone("T5 back-to-back");
    checkOutput("T5 back-to-back");
    @(negedge clk);
    check("T5 returns to idle", 32'({busy, done}), 32'b00);

    // T6: reset during the third busy cycle aborts the operation
    applyStimulus(16'h0F0F, 4'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("T6 still busy before abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("T6 abort Out", 32'(Out), 32'h0);
    check("T6 abort busy/done", 32'({busy, done}), 32'b00);
    rst_n = 1'b1;
    void'(scoreboard.pop_back());
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    check("T6 no done for aborted op", 32'(sawDone), 32'd0);

    // Random operations against the model
    for (int i = 0; i < 1000; i++) begin
      rIn  = WIDTH'($urandom);
      rCnt = CNT_W'($urandom_range(0, WIDTH - 1));
      rRot = 1'($urandom_range(0, 1));
      applyStimulus(rIn, rCnt, rRot);
      In  = WIDTH'($urandom);
      Cnt = CNT_W'($urandom);
      Rot = ~rRot;
      waitDone("random");
      checkOutput("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
